// File: rtl/pipeline_sequencer.sv
// -----------------------------------------------------------------------------
// pipeline_sequencer
//   Stall/flush controller for the 5-stage MIPS pipeline. Takes the load-use
//   hazard from ID and the taken-branch / halting-syscall events from EXE,
//   drives the PC and IF_ID / ID_EX enables and clears, sequences the
//   halt -> drain -> halt -> restart flow, and keeps saturating statistics
//   counters for the 7-seg display mux.
//
// Parameters
//   CNT_W        width of each statistics counter
//   DRAIN_CYCLES cycles (1..15) of PC freeze after halt_req so that MEM/WB
//                retire before the pipeline reports HALT
//
// Ports
//   clk          in  pipeline clock
//   rst          in  asynchronous reset, active-low
//   restart      in  sync pulse: leave HALT and resume fetch
//   bubble       in  load-use hazard detected in ID
//   branch_taken in  taken branch/jump resolved in EXE
//   halt_req     in  halting syscall in EXE
//   pc_en        out PC register load enable
//   if_id_en     out IF_ID load enable
//   if_id_clr    out IF_ID synchronous clear (insert nop)
//   id_ex_clr    out ID_EX synchronous clear (insert nop)
//   halted       out 1 while in HALT (registered)
//   cycle_cnt    out cycles spent in RUN or DRAIN
//   taken_cnt    out taken branches/jumps
//   bubble_cnt   out load-use bubbles inserted
// -----------------------------------------------------------------------------
module pipeline_sequencer #(
  parameter int CNT_W        = 16,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic             bubble,
  input  logic             branch_taken,
  input  logic             halt_req,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_clr,
  output logic             id_ex_clr,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_e;

  // The drain counter is loaded with DRAIN_CYCLES-1 and counts down to 0, so
  // the PC stays frozen in DRAIN for exactly DRAIN_CYCLES cycles.
  localparam logic [3:0]       DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_e           state_q,      state_d;
  logic [3:0]       drain_cnt_q,  drain_cnt_d;
  logic             halted_q,     halted_d;
  logic [CNT_W-1:0] cycle_cnt_q,  cycle_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q,  taken_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  logic taken_inc;
  logic bubble_inc;

  // Next-state and control-output logic. Control outputs are combinational so
  // a hazard takes effect in the same cycle it is reported.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // skips an assignment would otherwise infer a latch.
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    taken_inc   = 1'b0;
    bubble_inc  = 1'b0;
    // Frozen/flushed pipeline is the default; RUN overrides it.
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    if_id_clr   = 1'b1;
    id_ex_clr   = 1'b1;

    case (state_q)
      RUN: begin
        if (halt_req) begin
          drain_cnt_d = DRAIN_LOAD;
          state_d     = DRAIN;
        end else if (branch_taken) begin
          // Target is loaded through the PC mux; wrong-path IF and ID are
          // squashed. A coincident bubble is moot and not counted.
          pc_en     = 1'b1;
          if_id_en  = 1'b1;
          taken_inc = 1'b1;
        end else if (bubble) begin
          // Hold PC and IF_ID, push a nop into EXE.
          if_id_clr  = 1'b0;
          bubble_inc = 1'b1;
        end else begin
          pc_en     = 1'b1;
          if_id_en  = 1'b1;
          if_id_clr = 1'b0;
          id_ex_clr = 1'b0;
        end
      end
      DRAIN: begin
        if (drain_cnt_q == 4'd0) state_d = HALT;
        else                     drain_cnt_d = drain_cnt_q - 4'd1;
      end
      HALT: begin
        if (restart) state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    // While reset is held the pipeline registers are flushed and frozen,
    // regardless of what the (reset) state would otherwise request.
    if (!rst) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      if_id_clr = 1'b1;
      id_ex_clr = 1'b1;
    end

    halted_d = (state_d == HALT);

    cycle_cnt_d = cycle_cnt_q;
    if (state_q != HALT && cycle_cnt_q != CNT_MAX)
      cycle_cnt_d = cycle_cnt_q + CNT_ONE;

    taken_cnt_d = taken_cnt_q;
    if (taken_inc && taken_cnt_q != CNT_MAX)
      taken_cnt_d = taken_cnt_q + CNT_ONE;

    bubble_cnt_d = bubble_cnt_q;
    if (bubble_inc && bubble_cnt_q != CNT_MAX)
      bubble_cnt_d = bubble_cnt_q + CNT_ONE;
  end

  // NOTE: reset is asynchronous so the sequencer returns to RUN immediately,
  // even mid-DRAIN or in HALT, without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops
      // sample their _d values from the same edge.
      state_q      <= RUN;
      drain_cnt_q  <= 4'd0;
      halted_q     <= 1'b0;
      cycle_cnt_q  <= '0;
      taken_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      drain_cnt_q  <= drain_cnt_d;
      halted_q     <= halted_d;
      cycle_cnt_q  <= cycle_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign halted     = halted_q;
  assign cycle_cnt  = cycle_cnt_q;
  assign taken_cnt  = taken_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pipeline_sequencer
//   Directed, table-driven bench for pipeline_sequencer. Inputs change on the
//   falling edge; combinational controls are sampled mid-cycle and registered
//   outputs just after the rising edge. A second instance with CNT_W=4 covers
//   counter saturation.
// -----------------------------------------------------------------------------
module tb_pipeline_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (CNT_W=16, DRAIN_CYCLES=2)
  logic        rst, restart, bubble, branch_taken, halt_req;
  logic        pc_en, if_id_en, if_id_clr, id_ex_clr, halted;
  logic [15:0] cycle_cnt, taken_cnt, bubble_cnt;

  pipeline_sequencer #(.CNT_W(16), .DRAIN_CYCLES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .restart      (restart),
    .bubble       (bubble),
    .branch_taken (branch_taken),
    .halt_req     (halt_req),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .if_id_clr    (if_id_clr),
    .id_ex_clr    (id_ex_clr),
    .halted       (halted),
    .cycle_cnt    (cycle_cnt),
    .taken_cnt    (taken_cnt),
    .bubble_cnt   (bubble_cnt)
  );

  // Saturation instance (CNT_W=4), idle inputs
  logic       rst_s;
  logic       idle_s = 1'b0;
  logic       pc_en_s, if_id_en_s, if_id_clr_s, id_ex_clr_s, halted_s;
  logic [3:0] cycle_cnt_s, taken_cnt_s, bubble_cnt_s;

  pipeline_sequencer #(.CNT_W(4), .DRAIN_CYCLES(2)) dut_sat (
    .clk          (clk),
    .rst          (rst_s),
    .restart      (idle_s),
    .bubble       (idle_s),
    .branch_taken (idle_s),
    .halt_req     (idle_s),
    .pc_en        (pc_en_s),
    .if_id_en     (if_id_en_s),
    .if_id_clr    (if_id_clr_s),
    .id_ex_clr    (id_ex_clr_s),
    .halted       (halted_s),
    .cycle_cnt    (cycle_cnt_s),
    .taken_cnt    (taken_cnt_s),
    .bubble_cnt   (bubble_cnt_s)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One vector = one clock cycle.
  // ctl = {pc_en, if_id_en, if_id_clr, id_ex_clr} expected during the cycle;
  // halted/counters are the expected values right after the cycle's edge.
  typedef struct {
    string      name;
    logic       restart, bubble, branch, halt;
    logic [3:0] ctl;
    logic       halted;
    int         cyc, tak, bub;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input string name, input logic rs, input logic bb, input logic br,
                      input logic hr, input logic [3:0] ctl, input logic h,
                      input int cyc, input int tak, input int bub);
    vec_t v;
    v.name = name; v.restart = rs; v.bubble = bb; v.branch = br; v.halt = hr;
    v.ctl = ctl; v.halted = h; v.cyc = cyc; v.tak = tak; v.bub = bub;
    vecs.push_back(v);
  endtask

  task automatic check_ctl(input string name, input logic [3:0] exp);
    check({name, ".ctl"}, {28'd0, pc_en, if_id_en, if_id_clr, id_ex_clr}, {28'd0, exp});
  endtask

  task automatic check_regs(input string name, input logic h, input int cyc,
                            input int tak, input int bub);
    check({name, ".halted"},     {31'd0, halted}, {31'd0, h});
    check({name, ".cycle_cnt"},  {16'd0, cycle_cnt},  cyc);
    check({name, ".taken_cnt"},  {16'd0, taken_cnt},  tak);
    check({name, ".bubble_cnt"}, {16'd0, bubble_cnt}, bub);
  endtask

  localparam logic [3:0] NORM   = 4'b1100;
  localparam logic [3:0] FREEZE = 4'b0011;
  localparam logic [3:0] FLUSH  = 4'b1111;
  localparam logic [3:0] STALL  = 4'b0001;

  initial begin
    rst = 1'b0; rst_s = 1'b0;
    restart = 1'b0; bubble = 1'b0; branch_taken = 1'b0; halt_req = 1'b0;

    // ---------------- stimulus table ----------------
    for (int i = 1; i <= 10; i++) addv("idle", 0,0,0,0, NORM, 0, i, 0, 0);
    addv("bubble",          0,1,0,0, STALL,  0, 11, 0, 1);
    addv("after_bubble",    0,0,0,0, NORM,   0, 12, 0, 1);
    addv("branch+bubble",   0,1,1,0, FLUSH,  0, 13, 1, 1);
    addv("after_branch",    0,0,0,0, NORM,   0, 14, 1, 1);
    addv("halt_N",          0,0,0,1, FREEZE, 0, 15, 1, 1);
    addv("drain1_ignored",  1,1,1,1, FREEZE, 0, 16, 1, 1);
    addv("drain2",          0,0,0,0, FREEZE, 1, 17, 1, 1);
    addv("halt_ignored",    0,1,1,1, FREEZE, 1, 17, 1, 1);
    addv("halt_idle",       0,0,0,0, FREEZE, 1, 17, 1, 1);
    addv("restart_M",       1,0,0,0, FREEZE, 0, 17, 1, 1);
    addv("resume_M+1",      0,0,0,0, NORM,   0, 18, 1, 1);
    addv("restart_in_run",  1,0,0,0, NORM,   0, 19, 1, 1);
    addv("branch",          0,0,1,0, FLUSH,  0, 20, 2, 1);
    addv("bubble2",         0,1,0,0, STALL,  0, 21, 2, 2);
    addv("halt_prio",       0,1,1,1, FREEZE, 0, 22, 2, 2);
    addv("drain_a",         0,0,0,0, FREEZE, 0, 23, 2, 2);

    // ---------------- reset state ----------------
    #2;
    check_ctl("reset", FREEZE);
    check_regs("reset", 0, 0, 0, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // ---------------- table ----------------
    foreach (vecs[i]) begin
      restart      = vecs[i].restart;
      bubble       = vecs[i].bubble;
      branch_taken = vecs[i].branch;
      halt_req     = vecs[i].halt;
      #1;
      check_ctl(vecs[i].name, vecs[i].ctl);
      @(posedge clk); #1;
      check_regs(vecs[i].name, vecs[i].halted, vecs[i].cyc, vecs[i].tak, vecs[i].bub);
      @(negedge clk);
    end
    restart = 1'b0; bubble = 1'b0; branch_taken = 1'b0; halt_req = 1'b0;

    // ---------------- reset during DRAIN ----------------
    // Still in DRAIN (second drain cycle pending). Assert rst mid-cycle.
    rst = 1'b0;
    #1;
    check_ctl("rst_in_drain", FREEZE);
    check_regs("rst_in_drain", 0, 0, 0, 0);
    @(posedge clk); #1;
    check_regs("rst_held", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_ctl("post_rst_first", NORM);
    @(posedge clk); #1;
    check_regs("post_rst_first", 0, 1, 0, 0);
    @(negedge clk);
    halt_req = 1'b1;
    #1;
    check_ctl("post_rst_halt", FREEZE);
    @(posedge clk); #1;
    halt_req = 1'b0;
    check_regs("post_rst_halt", 0, 2, 0, 0);

    // ---------------- saturation, CNT_W=4 ----------------
    @(negedge clk);
    rst_s = 1'b1;
    for (int i = 0; i < 15; i++) @(posedge clk);
    #1;
    check("sat.cycle_15", {28'd0, cycle_cnt_s}, 32'd15);
    for (int i = 0; i < 5; i++) @(posedge clk);
    #1;
    check("sat.cycle_20", {28'd0, cycle_cnt_s}, 32'd15);
    check("sat.pc_en", {31'd0, pc_en_s}, 32'd1);
    check("sat.halted", {31'd0, halted_s}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
